regfile_dbg_master: RTL

Command-driven initiator for the register-file read/write port pair. It accepts single-register READ/WRITE commands plus bulk CLEAR and DUMP commands over a valid/ready command channel. It sequences the register-file write port (we/addr/data) and one read port (addr/data), and returns read data over a valid/ready response channel. It sits beside the pipelined core as the debug/test path into the architectural registers. While `rf_own` is high, the core is muxed off the ports.

---
 rtl/regfile_dbg_pkg.sv | 26 ++
 rtl/regfile_dbg_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/regfile_dbg_pkg.sv
// Shared types and default sizes for the register-file debug master.
// No logic of its own; latency n/a.
// Backpressure n/a.
package regfile_dbg_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Command opcodes as they appear on cmd_op
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_DUMP  = 2'b11
  } op_e;

  // Sequencer states; anything other than S_IDLE owns the register-file ports
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_CLR,
    S_RD,
    S_RSP
  } state_e;

endpackage

// File: rtl/regfile_dbg_master.sv
// Debug/test initiator driving the register-file write port and one read port from commands.
// Latency: WRITE 1 cycle, READ 2 cycles min, CLEAR NREG-1 cycles, DUMP 2*NREG cycles min.
// Backpressure: one command in flight, cmd_ready only in IDLE; rsp held stable until rsp_ready.
module regfile_dbg_master
  import regfile_dbg_pkg::*;
#(
  parameter int  XLEN = XLEN_DEF,
  parameter int  NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [AW-1:0]   rsp_addr,
  output logic [XLEN-1:0] rsp_data,
  output logic            rf_own,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [AW-1:0]   rf_ra,
  input  logic [XLEN-1:0] rf_rd
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic            dump_q;
  logic            live_q;     // low during reset so cmd_ready reads 0 until the first clean cycle
  logic [AW-1:0]   wa_q;
  logic [XLEN-1:0] wd_q;
  logic [AW-1:0]   rsp_addr_q;
  logic [XLEN-1:0] rsp_data_q;

  // Sequencer: state, index counter, latched write command and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      dump_q     <= 1'b0;
      live_q     <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            case (op_e'(cmd_op))
              OP_READ: begin
                state_q <= S_RD;
                idx_q   <= cmd_addr;
                dump_q  <= 1'b0;
              end
              OP_WRITE: begin
                state_q <= S_WR;
                wa_q    <= cmd_addr;
                wd_q    <= cmd_wdata;
              end
              OP_CLEAR: begin
                state_q <= S_CLR;
                idx_q   <= ONE_IDX;
              end
              default: begin
                state_q <= S_RD;
                idx_q   <= '0;
                dump_q  <= 1'b1;
              end
            endcase
          end
        end
        S_WR: begin
          state_q <= S_IDLE;
        end
        S_CLR: begin
          idx_q <= idx_q + ONE_IDX;
          if (idx_q == LAST_IDX) begin
            state_q <= S_IDLE;
          end
        end
        S_RD: begin
          // x0 reads as zero regardless of what the register file returns
          rsp_addr_q <= idx_q;
          rsp_data_q <= (idx_q == '0) ? '0 : rf_rd;
          state_q    <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            if (!dump_q || idx_q == LAST_IDX) begin
              state_q <= S_IDLE;
            end else begin
              idx_q   <= idx_q + ONE_IDX;
              state_q <= S_RD;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; unused port fields are driven to zero
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && live_q;
    rsp_valid = (state_q == S_RSP);
    rf_own    = (state_q != S_IDLE);
    rsp_addr  = rsp_addr_q;
    rsp_data  = rsp_data_q;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    rf_ra     = '0;
    case (state_q)
      S_WR: begin
        // writes to x0 are silently dropped
        if (wa_q != '0) begin
          rf_we = 1'b1;
          rf_wa = wa_q;
          rf_wd = wd_q;
        end
      end
      S_CLR: begin
        rf_we = 1'b1;
        rf_wa = idx_q;
      end
      S_RD: begin
        rf_ra = idx_q;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

endmodule
